// File: rtl/pipe_stage_skid_pkg.sv
// Shared types and constants for the generic pipeline stage register:
// FSM state encoding, occupancy width and the default no-op control bundle.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  localparam int OCC_W = 2;

  // Bundles wider than 64 bits would need a wider default here.
  localparam logic [63:0] CTRL_BUBBLE_DEF = 64'h0;

  function automatic logic [OCC_W-1:0] occ_of(input state_e s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle between two pipeline stages.
// The stage register uses the slave view; the upstream/downstream driver uses master.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 24
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_stage_skid_entry.sv
// pipe_entry_reg: one control+payload entry with load enable and a
// synchronous clear that writes the no-op bundle and a zero payload.
module pipe_entry_reg #(
  parameter int                DATA_W      = 16,
  parameter int                CTRL_W      = 24,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl <= CTRL_BUBBLE;
      r_data <= '0;
    end else if (i_clear) begin
      r_ctrl <= CTRL_BUBBLE;
      r_data <= '0;
    end else if (i_load) begin
      r_ctrl <= i_ctrl;
      r_data <= i_data;
    end
  end

  assign o_ctrl = r_ctrl;
  assign o_data = r_data;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with a 2-entry skid buffer and flush.
// Optional PIPE_STAGE_PERF_EN adds saturating stall/bubble counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                CTRL_W      = 24,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = CTRL_BUBBLE_DEF[CTRL_W-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_stage_skid_if.slave bus,
`ifdef PIPE_STAGE_PERF_EN
  output logic [15:0]      stall_cnt,
  output logic [15:0]      bubble_cnt,
`endif
  output logic [OCC_W-1:0] occupancy
);

  state_e r_state;
  state_e w_state_nxt;

  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_accept;
  logic              w_fire;
  logic              w_main_load;
  logic              w_main_from_skid;
  logic              w_skid_load;
  logic [CTRL_W-1:0] w_main_ctrl_d;
  logic [DATA_W-1:0] w_main_data_d;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic [DATA_W-1:0] w_main_data;
  logic [CTRL_W-1:0] w_skid_ctrl;
  logic [DATA_W-1:0] w_skid_data;

  // Handshake outputs come from the state register only, so out_ready
  // never reaches in_ready combinationally.
  assign w_in_ready  = (r_state != ST_TWO);
  assign w_out_valid = (r_state != ST_EMPTY);
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_fire      = w_out_valid & bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_main_load      = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_load      = 1'b0;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_ONE;
            w_main_load = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_fire) begin
            w_main_load = 1'b1;
          end else if (w_accept) begin
            w_state_nxt = ST_TWO;
            w_skid_load = 1'b1;
          end else if (w_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_fire) begin
            w_state_nxt      = ST_ONE;
            w_main_load      = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  assign w_main_ctrl_d = w_main_from_skid ? w_skid_ctrl : bus.in_ctrl;
  assign w_main_data_d = w_main_from_skid ? w_skid_data : bus.in_data;

  // main/skid stage boundary
  pipe_entry_reg #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .CTRL_BUBBLE (CTRL_BUBBLE)
  ) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_main_load),
    .i_clear (flush),
    .i_ctrl  (w_main_ctrl_d),
    .i_data  (w_main_data_d),
    .o_ctrl  (w_main_ctrl),
    .o_data  (w_main_data)
  );

  pipe_entry_reg #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .CTRL_BUBBLE (CTRL_BUBBLE)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (flush),
    .i_ctrl  (bus.in_ctrl),
    .i_data  (bus.in_data),
    .o_ctrl  (w_skid_ctrl),
    .o_data  (w_skid_data)
  );

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  // A drained stage keeps its stale payload but presents a no-op bundle.
  assign bus.out_ctrl  = (r_state == ST_EMPTY) ? CTRL_BUBBLE : w_main_ctrl;
  assign bus.out_data  = w_main_data;
  assign occupancy     = occ_of(r_state);

`ifdef PIPE_STAGE_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] r_stall_cnt;
  logic [15:0] r_bubble_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_out_valid && !bus.out_ready)
        r_stall_cnt <= sat_inc(r_stall_cnt);
      if ((r_state == ST_EMPTY) || flush)
        r_bubble_cnt <= sat_inc(r_bubble_cnt);
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
